// File: rtl/wave_meter_pkg.sv
// ---------------------------------------------------------------------------
// wave_meter_pkg
// Shared types and constants for the wave_meter period/amplitude meter.
//   wm_state_e  : per-channel measurement FSM state (SEEK, ARM, MEAS)
//   AVG_DEPTH   : results averaged per output when WAVE_METER_AVG_EN is defined
//   AVG_SHIFT   : log2(AVG_DEPTH), divides the boxcar sum
//   amp_width() : width of an unsigned max-min span of W-bit signed samples
// ---------------------------------------------------------------------------
package wave_meter_pkg;

   typedef enum logic [1:0] {
      SEEK = 2'd0,   // waiting for a sample at or below -HYST
      ARM  = 2'd1,   // below seen, waiting for the first rising crossing
      MEAS = 2'd2    // inside a measurement window
   } wm_state_e;

   localparam int AVG_DEPTH = 4;
   localparam int AVG_SHIFT = 2;

   // max - min of two W-bit signed values needs one extra bit to never wrap
   function automatic int amp_width(input int w);
      return w + 1;
   endfunction

endpackage

// File: rtl/wave_meter_ch.sv
// ---------------------------------------------------------------------------
// wave_meter_ch
// One measurement channel: hysteretic rising-crossing detector, SEEK/ARM/MEAS
// FSM, period counter and running min/max. Emits one registered result per
// period. With WAVE_METER_AVG_EN defined, results pass through a 4-deep
// boxcar and are only reported once four results have accumulated since the
// last restart or timeout.
//
// Handshake: smp_vld_i qualifies smp_i; no state moves while it is low.
// res_vld_o and timeout_o are single-cycle pulses; period_o/amp_o hold
// between results.
//
// Ports
//   clk_i, rst_i, clr_i : clock, synchronous active-high reset / restart
//   smp_vld_i, smp_i    : sample strobe and signed sample
//   res_vld_o           : new result on period_o / amp_o
//   period_o            : samples in the last period (or boxcar average)
//   amp_o               : max - min over the last period (or boxcar average)
//   timeout_o           : counter saturated, channel returned to SEEK
//   state_o             : current FSM state, for debug observation
// ---------------------------------------------------------------------------
module wave_meter_ch
   import wave_meter_pkg::*;
#(
   parameter int W    = 16,
   parameter int PW   = 16,
   parameter int HYST = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       clr_i,
   input  logic                       smp_vld_i,
   input  logic signed [W-1:0]        smp_i,
   output logic                       res_vld_o,
   output logic [PW-1:0]              period_o,
   output logic [amp_width(W)-1:0]    amp_o,
   output logic                       timeout_o,
   output wm_state_e                  state_o
);

   localparam int AW = amp_width(W);
   localparam logic signed [W-1:0] HYST_P = W'(HYST);
   localparam logic signed [W-1:0] HYST_N = -HYST_P;
   // Last count value before saturation; the sample that would reach
   // 2**PW-1 triggers the timeout instead.
   localparam logic [PW-1:0] CNT_LAST = {{(PW-1){1'b1}}, 1'b0};

   wm_state_e               state_q, state_d;
   logic                    below_q, below_d;
   logic [PW-1:0]           cnt_q, cnt_d;
   logic signed [W-1:0]     min_q, min_d;
   logic signed [W-1:0]     max_q, max_d;
   logic                    res_vld_q, res_vld_d;
   logic [PW-1:0]           period_q, period_d;
   logic [AW-1:0]           amp_q, amp_d;
   logic                    timeout_q, timeout_d;

   logic                    is_low, is_high, crossing, emit;
   logic [AW-1:0]           win_amp;

   assign is_low   = (smp_i <= HYST_N);
   assign is_high  = (smp_i >= HYST_P);
   assign crossing = below_q && is_high;

   // Sign-extend both ends before subtracting so the span never wraps.
   assign win_amp  = {max_q[W-1], max_q} - {min_q[W-1], min_q};

   // ------------------------------------------------------------------
   // Crossing FSM, counter and min/max
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      below_d   = below_q;
      cnt_d     = cnt_q;
      min_d     = min_q;
      max_d     = max_q;
      emit      = 1'b0;
      timeout_d = 1'b0;
      if (smp_vld_i) begin
         case (state_q)
            SEEK: begin
               if (is_low) begin
                  state_d = ARM;
                  below_d = 1'b1;
               end
            end
            ARM: begin
               if (crossing) begin
                  state_d = MEAS;
                  below_d = 1'b0;
                  cnt_d   = PW'(1);
                  min_d   = smp_i;
                  max_d   = smp_i;
               end
            end
            MEAS: begin
               if (crossing) begin
                  // Crossing sample closes this window and seeds the next.
                  emit    = 1'b1;
                  below_d = 1'b0;
                  cnt_d   = PW'(1);
                  min_d   = smp_i;
                  max_d   = smp_i;
               end else if (cnt_q == CNT_LAST) begin
                  timeout_d = 1'b1;
                  state_d   = SEEK;
                  below_d   = 1'b0;
                  cnt_d     = '0;
                  min_d     = '0;
                  max_d     = '0;
               end else begin
                  cnt_d = cnt_q + PW'(1);
                  if (smp_i < min_q) min_d = smp_i;
                  if (smp_i > max_q) max_d = smp_i;
                  if (is_low) below_d = 1'b1;
               end
            end
            default: begin
               state_d = SEEK;
               below_d = 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Result path
   // ------------------------------------------------------------------
`ifdef WAVE_METER_AVG_EN
   localparam int FW = $clog2(AVG_DEPTH);
   localparam logic [FW-1:0] FILL_FULL = FW'(AVG_DEPTH - 1);

   // Only the previous AVG_DEPTH-1 results are stored; the current one
   // completes the window combinationally.
   logic [PW-1:0] hist_p_q [AVG_DEPTH-1];
   logic [PW-1:0] hist_p_d [AVG_DEPTH-1];
   logic [AW-1:0] hist_a_q [AVG_DEPTH-1];
   logic [AW-1:0] hist_a_d [AVG_DEPTH-1];
   logic [FW-1:0] fill_q, fill_d;
   logic [PW+1:0] psum;
   logic [AW+1:0] asum;

   always_comb begin
      res_vld_d = 1'b0;
      period_d  = period_q;
      amp_d     = amp_q;
      fill_d    = fill_q;
      hist_p_d  = hist_p_q;
      hist_a_d  = hist_a_q;
      psum      = (PW+2)'(cnt_q);
      asum      = (AW+2)'(win_amp);
      for (int i = 0; i < AVG_DEPTH - 1; i++) begin
         psum = psum + (PW+2)'(hist_p_q[i]);
         asum = asum + (AW+2)'(hist_a_q[i]);
      end
      if (emit) begin
         hist_p_d[0] = cnt_q;
         hist_a_d[0] = win_amp;
         for (int i = 1; i < AVG_DEPTH - 1; i++) begin
            hist_p_d[i] = hist_p_q[i-1];
            hist_a_d[i] = hist_a_q[i-1];
         end
         if (fill_q == FILL_FULL) begin
            res_vld_d = 1'b1;
            period_d  = PW'(psum >> AVG_SHIFT);
            amp_d     = AW'(asum >> AVG_SHIFT);
         end else begin
            fill_d = fill_q + FW'(1);
         end
      end
      if (timeout_d) begin
         fill_d = '0;
         for (int i = 0; i < AVG_DEPTH - 1; i++) begin
            hist_p_d[i] = '0;
            hist_a_d[i] = '0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         fill_q <= '0;
         for (int i = 0; i < AVG_DEPTH - 1; i++) begin
            hist_p_q[i] <= '0;
            hist_a_q[i] <= '0;
         end
      end else begin
         fill_q   <= fill_d;
         hist_p_q <= hist_p_d;
         hist_a_q <= hist_a_d;
      end
   end
`else
   always_comb begin
      res_vld_d = 1'b0;
      period_d  = period_q;
      amp_d     = amp_q;
      if (emit) begin
         res_vld_d = 1'b1;
         period_d  = cnt_q;
         amp_d     = win_amp;
      end
   end
`endif

   // ------------------------------------------------------------------
   // State register; clr has the same effect as reset.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         state_q   <= SEEK;
         below_q   <= 1'b0;
         cnt_q     <= '0;
         min_q     <= '0;
         max_q     <= '0;
         res_vld_q <= 1'b0;
         period_q  <= '0;
         amp_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         below_q   <= below_d;
         cnt_q     <= cnt_d;
         min_q     <= min_d;
         max_q     <= max_d;
         res_vld_q <= res_vld_d;
         period_q  <= period_d;
         amp_q     <= amp_d;
         timeout_q <= timeout_d;
      end
   end

   assign res_vld_o = res_vld_q;
   assign period_o  = period_q;
   assign amp_o     = amp_q;
   assign timeout_o = timeout_q;
   assign state_o   = state_q;

endmodule

// File: rtl/wave_meter.sv
// ---------------------------------------------------------------------------
// wave_meter
// Multi-channel period/amplitude meter for signed audio samples. Each
// channel independently finds rising zero crossings with hysteresis and
// reports samples-per-period and max-min amplitude once per period.
// Optional macro WAVE_METER_AVG_EN: 4-deep boxcar average per channel.
//
// Handshake: smp_vld qualifies all NCH samples at once; nothing advances
// while it is low. res_vld and timeout are 1-cycle pulses per channel.
//
// Ports
//   clk, rst, clr : clock, synchronous active-high reset, synchronous restart
//   smp_vld       : shared sample strobe
//   smp           : NCH signed samples, channel c at [c*W +: W]
//   res_vld       : per-channel result pulse
//   period        : per-channel period, channel c at [c*PW +: PW]
//   amp           : per-channel amplitude, channel c at [c*(W+1) +: W+1]
//   timeout       : per-channel counter-saturation pulse
//   dbg_state     : per-channel FSM state (wm_state_e), channel c at [c*2 +: 2]
// ---------------------------------------------------------------------------
module wave_meter
   import wave_meter_pkg::*;
#(
   parameter int NCH  = 2,
   parameter int W    = 16,
   parameter int PW   = 16,
   parameter int HYST = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clr,
   input  logic                        smp_vld,
   input  logic [NCH*W-1:0]            smp,
   output logic [NCH-1:0]              res_vld,
   output logic [NCH*PW-1:0]           period,
   output logic [NCH*(W+1)-1:0]        amp,
   output logic [NCH-1:0]              timeout,
   output logic [2*NCH-1:0]            dbg_state
);

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      wm_state_e ch_state;

      wave_meter_ch #(
         .W    (W),
         .PW   (PW),
         .HYST (HYST)
      ) u_ch (
         .clk_i     (clk),
         .rst_i     (rst),
         .clr_i     (clr),
         .smp_vld_i (smp_vld),
         .smp_i     (smp[c*W +: W]),
         .res_vld_o (res_vld[c]),
         .period_o  (period[c*PW +: PW]),
         .amp_o     (amp[c*(W+1) +: W+1]),
         .timeout_o (timeout[c]),
         .state_o   (ch_state)
      );

      assign dbg_state[c*2 +: 2] = ch_state;
   end

endmodule

// File: tb/tb_wave_meter.sv
// ---------------------------------------------------------------------------
// tb_wave_meter
// Directed + randomized bench for wave_meter (NCH=2, W=16, PW=16, HYST=16).
// A window-based reference model keeps the samples of each open period in a
// queue and derives period/amplitude from that queue at each crossing.
// ---------------------------------------------------------------------------
module tb_wave_meter;
   import wave_meter_pkg::*;

   localparam int NCH  = 2;
   localparam int W    = 16;
   localparam int PW   = 16;
   localparam int HYST = 16;
   localparam int AW   = W + 1;
   localparam int CMAX = (1 << PW) - 1;
   localparam int BW   = 2*NCH + NCH*PW + NCH*AW + 2*NCH;
   localparam real PI  = 3.14159265358979;

   // ---------------- clock / reset ----------------
   logic                 clk = 1'b0;
   logic                 rst, clr, smp_vld;
   logic [NCH*W-1:0]     smp;
   logic [NCH-1:0]       res_vld, timeout;
   logic [NCH*PW-1:0]    period;
   logic [NCH*AW-1:0]    amp;
   logic [2*NCH-1:0]     dbg_state;

   always #5 clk = ~clk;

   wave_meter #(.NCH(NCH), .W(W), .PW(PW), .HYST(HYST)) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .smp_vld   (smp_vld),
      .smp       (smp),
      .res_vld   (res_vld),
      .period    (period),
      .amp       (amp),
      .timeout   (timeout),
      .dbg_state (dbg_state)
   );

   // ---------------- reference model ----------------
   int n_vec = 0;
   int n_err = 0;

   int m_mode  [NCH];      // 0 seeking, 1 armed, 2 measuring
   bit m_below [NCH];
   int win_q   [NCH][$];   // samples of the open window
   int hp_q    [NCH][$];   // recent raw periods (averaging build)
   int ha_q    [NCH][$];   // recent raw amplitudes (averaging build)
   bit e_vld   [NCH];
   bit e_to    [NCH];
   int e_per   [NCH];
   int e_amp   [NCH];

   // observations of the DUT for directed checks
   int obs_res  [NCH];
   int obs_to   [NCH];
   int last_per [NCH];
   int last_amp [NCH];
   int obs_p0_q [$];

   function automatic void model_emit(int c);
      int mn, mx, n;
      n  = win_q[c].size();
      mn = win_q[c][0];
      mx = mn;
      for (int i = 1; i < n; i++) begin
         if (win_q[c][i] < mn) mn = win_q[c][i];
         if (win_q[c][i] > mx) mx = win_q[c][i];
      end
`ifdef WAVE_METER_AVG_EN
      hp_q[c].push_back(n);
      ha_q[c].push_back(mx - mn);
      if (hp_q[c].size() > 4) begin
         void'(hp_q[c].pop_front());
         void'(ha_q[c].pop_front());
      end
      if (hp_q[c].size() == 4) begin
         int sp, sa;
         sp = 0;
         sa = 0;
         for (int i = 0; i < 4; i++) begin
            sp += hp_q[c][i];
            sa += ha_q[c][i];
         end
         e_vld[c] = 1'b1;
         e_per[c] = sp / 4;
         e_amp[c] = sa / 4;
      end
`else
      e_vld[c] = 1'b1;
      e_per[c] = n;
      e_amp[c] = mx - mn;
`endif
   endfunction

   function automatic void model_step(bit r, bit cl, bit vld, int s0, int s1);
      for (int c = 0; c < NCH; c++) begin
         int  s;
         bit  low, high;
         s        = (c == 0) ? s0 : s1;
         low      = (s <= -HYST);
         high     = (s >= HYST);
         e_vld[c] = 1'b0;
         e_to[c]  = 1'b0;
         if (r || cl) begin
            m_mode[c]  = 0;
            m_below[c] = 1'b0;
            e_per[c]   = 0;
            e_amp[c]   = 0;
            win_q[c].delete();
            hp_q[c].delete();
            ha_q[c].delete();
         end else if (vld) begin
            if (m_mode[c] == 0) begin
               if (low) begin
                  m_mode[c]  = 1;
                  m_below[c] = 1'b1;
               end
            end else if (m_below[c] && high) begin
               if (m_mode[c] == 2) model_emit(c);
               m_mode[c]  = 2;
               m_below[c] = 1'b0;
               win_q[c].delete();
               win_q[c].push_back(s);
            end else if (m_mode[c] == 2) begin
               win_q[c].push_back(s);
               if (low) m_below[c] = 1'b1;
               if (win_q[c].size() == CMAX) begin
                  e_to[c]    = 1'b1;
                  m_mode[c]  = 0;
                  m_below[c] = 1'b0;
                  win_q[c].delete();
                  hp_q[c].delete();
                  ha_q[c].delete();
               end
            end else if (low) begin
               m_below[c] = 1'b1;
            end
         end
      end
   endfunction

   // ---------------- scoreboard compare ----------------
   task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input int s0, input int s1, input bit vld, input bit cl, input bit r);
      logic [NCH-1:0]    ev, et;
      logic [NCH*PW-1:0] ep;
      logic [NCH*AW-1:0] ea;
      logic [2*NCH-1:0]  es;
      smp     = {s1[W-1:0], s0[W-1:0]};
      smp_vld = vld;
      clr     = cl;
      rst     = r;
      model_step(r, cl, vld, s0, s1);
      @(posedge clk);
      #1;
      for (int c = 0; c < NCH; c++) begin
         ev[c]          = e_vld[c];
         et[c]          = e_to[c];
         ep[c*PW +: PW] = PW'(e_per[c]);
         ea[c*AW +: AW] = AW'(e_amp[c]);
         es[c*2 +: 2]   = (m_mode[c] == 0) ? SEEK : (m_mode[c] == 1) ? ARM : MEAS;
      end
      check("cycle", {res_vld, timeout, period, amp, dbg_state}, {ev, et, ep, ea, es});
      for (int c = 0; c < NCH; c++) begin
         if (res_vld[c]) begin
            obs_res[c]++;
            last_per[c] = int'(period[c*PW +: PW]);
            last_amp[c] = int'(amp[c*AW +: AW]);
            if (c == 0) obs_p0_q.push_back(last_per[c]);
         end
         if (timeout[c]) obs_to[c]++;
      end
   endtask

   task automatic clear_obs();
      for (int c = 0; c < NCH; c++) begin
         obs_res[c] = 0;
         obs_to[c]  = 0;
      end
      obs_p0_q.delete();
   endtask

   function automatic int sine(int a, int p, int k);
      real r;
      r = a * $sin(2.0 * PI * k / p);
      return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
   endfunction

   function automatic int sq(int p, int k, int a);
      return ((k % p) < p / 2) ? -a : a;
   endfunction

   // ---------------- stimulus ----------------
   int half [NCH];
   int left [NCH];
   int lvl  [NCH];
   int sgn  [NCH];
   int rs   [NCH];

   initial begin
      rst = 1'b1; clr = 1'b0; smp_vld = 1'b0; smp = '0;
      for (int c = 0; c < NCH; c++) begin
         m_mode[c] = 0; m_below[c] = 1'b0; e_per[c] = 0; e_amp[c] = 0;
         last_per[c] = 0; last_amp[c] = 0;
      end
      clear_obs();

      // reset state
      step(0, 0, 1'b0, 1'b0, 1'b1);
      step(1000, -1000, 1'b1, 1'b0, 1'b1);
      check("reset_outputs", BW'({res_vld, timeout, period, amp, dbg_state}), '0);

      // square +/-1000, period 10, on channel 0
      clear_obs();
      for (int k = 0; k < 60; k++) step(sq(10, k, 1000), 0, 1'b1, 1'b0, 1'b0);
      check("sq_period", BW'(last_per[0]), BW'(10));
      check("sq_amp", BW'(last_amp[0]), BW'(2000));
`ifdef WAVE_METER_AVG_EN
      check("sq_results", BW'(obs_res[0]), BW'(2));
`else
      check("sq_results", BW'(obs_res[0]), BW'(5));
`endif

      // two independent sines with small random jitter
      for (int k = 0; k < 240; k++)
         step(sine(500, 8, k) + int'($urandom_range(0, 6)) - 3,
              sine(3000, 20, k) + int'($urandom_range(0, 6)) - 3, 1'b1, 1'b0, 1'b0);
      check("sine0_period", BW'(last_per[0]), BW'(8));
      check("sine1_period", BW'(last_per[1]), BW'(20));
      check("sine0_amp_near_1000", BW'(last_amp[0] >= 990 && last_amp[0] <= 1010), BW'(1));
      check("sine1_amp_near_6000", BW'(last_amp[1] >= 5990 && last_amp[1] <= 6010), BW'(1));

      // square period 10 with smp_vld toggling
      for (int k = 0; k < 120; k++)
         step(sq(10, k / 2, 1000), 0, (k % 2) == 0, 1'b0, 1'b0);
      check("gated_period", BW'(last_per[0]), BW'(10));

      // arm, then DC 0 until the counter saturates, then square again
      for (int k = 0; k < 20; k++) step(sq(10, k, 1000), 0, 1'b1, 1'b0, 1'b0);
      clear_obs();
      for (int k = 0; k < CMAX + 5; k++) step(0, 0, 1'b1, 1'b0, 1'b0);
      check("dc_timeouts", BW'(obs_to[0]), BW'(1));
      check("dc_no_result", BW'(obs_res[0]), BW'(0));
      for (int k = 0; k < 40; k++) step(sq(10, k, 1000), sq(10, k, 1000), 1'b1, 1'b0, 1'b0);

      // noise inside the hysteresis band, then clr on a crossing sample
      step(0, 0, 1'b1, 1'b1, 1'b0);
      clear_obs();
      for (int k = 0; k < 300; k++)
         step(int'($urandom_range(0, 20)) - 10, int'($urandom_range(0, 20)) - 10, 1'b1, 1'b0, 1'b0);
      check("noise_no_result", BW'(obs_res[0] + obs_res[1]), BW'(0));
      check("noise_no_timeout", BW'(obs_to[0] + obs_to[1]), BW'(0));
      for (int k = 0; k < 5; k++) step(-1000, 0, 1'b1, 1'b0, 1'b0);
      step(1000, 0, 1'b1, 1'b1, 1'b0);
      check("clr_state_seek", BW'(dbg_state), BW'(0));
      for (int k = 0; k < 5; k++) step(1000, 0, 1'b1, 1'b0, 1'b0);
      check("clr_no_result", BW'(obs_res[0]), BW'(0));

      // periods 10,10,12,12,14 after a restart
      step(0, 0, 1'b1, 1'b1, 1'b0);
      clear_obs();
      for (int k = 0; k < 3; k++) step(-800, 0, 1'b1, 1'b0, 1'b0);
      begin
         int plist[5] = '{10, 10, 12, 12, 14};
         foreach (plist[i]) begin
            for (int k = 0; k < plist[i] / 2; k++) step(800, 0, 1'b1, 1'b0, 1'b0);
            for (int k = 0; k < plist[i] - plist[i] / 2; k++) step(-800, 0, 1'b1, 1'b0, 1'b0);
         end
      end
      step(800, 0, 1'b1, 1'b0, 1'b0);
`ifdef WAVE_METER_AVG_EN
      check("avg_count", BW'(obs_p0_q.size()), BW'(2));
      if (obs_p0_q.size() == 2) begin
         check("avg_first", BW'(obs_p0_q[0]), BW'(11));
         check("avg_second", BW'(obs_p0_q[1]), BW'(12));
      end
`else
      check("raw_count", BW'(obs_p0_q.size()), BW'(5));
      if (obs_p0_q.size() == 5) begin
         check("raw_third", BW'(obs_p0_q[2]), BW'(12));
         check("raw_fifth", BW'(obs_p0_q[4]), BW'(14));
      end
`endif

      // randomized squares with noise, gaps, occasional clr and one reset
      for (int c = 0; c < NCH; c++) begin
         half[c] = 1 + int'($urandom_range(0, 14));
         left[c] = half[c];
         lvl[c]  = int'($urandom_range(0, 32000));
         sgn[c]  = -1;
      end
      for (int i = 0; i < 3000; i++) begin
         bit v, cl, r;
         v  = ($urandom_range(0, 3) != 0);
         cl = ($urandom_range(0, 499) == 0);
         r  = (i == 1500);
         for (int c = 0; c < NCH; c++) begin
            rs[c] = sgn[c] * lvl[c] + int'($urandom_range(0, 40)) - 20;
            if (v) begin
               left[c]--;
               if (left[c] == 0) begin
                  sgn[c] = -sgn[c];
                  if ($urandom_range(0, 3) == 0) half[c] = 1 + int'($urandom_range(0, 14));
                  if ($urandom_range(0, 7) == 0) lvl[c] = int'($urandom_range(0, 32000));
                  left[c] = half[c];
               end
            end
         end
         step(rs[0], rs[1], v, cl, r);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
